rvfi_reorder_buffer: RTL and testbench
======================================

Name: rvfi_reorder_buffer

Overview:
- Sits between the core's RVFI retirement ports and the single-channel RVFI consumers (memory, register and PC checkers).
- Accepts up to NRET retirement packets per cycle, each tagged with an 8-bit order number, in any order.
- Re-emits them one per cycle on a single channel in strictly increasing order (mod 256).
- Flags protocol violations: duplicate order, out-of-window order, or a slot collision.

Parameters:
- NRET, 1, number of input retirement channels (1..4).
- DEPTH, 16, buffer slots; power of two, 2..128; also the reorder window size.
- PKTW, 312, payload width per packet, opaque to this block. The default is the RV32 RVFI field set excluding valid and order.

Ports:
- clk  input  1  clock, all state updates on rising edge
- resetn  input  1  synchronous active-low reset
- in_valid  input  NRET  per-channel retirement valid
- in_order  input  NRET*8  per-channel order tag, channel k at [k*8 +: 8]
- in_pkt  input  NRET*PKTW  per-channel payload, channel k at [k*PKTW +: PKTW]
- out_valid  output  1  one in-order packet presented this cycle
- out_order  output  8  order tag of presented packet
- out_pkt  output  PKTW  payload of presented packet
- error  output  1  sticky protocol-violation flag
- occupancy  output  $clog2(DEPTH)+1  number of occupied slots

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. All outputs are registered.
- Reset values when resetn=0 at an edge:
  - out_valid=0, out_order=0, out_pkt=0, error=0, occupancy=0.
  - All slots marked empty; next_order counter = 0.
- Storage: DEPTH slots, each holding an occupied bit, an 8-bit order and a PKTW payload. Slot index = order[$clog2(DEPTH)-1:0].
- Window check for each valid channel k: dist = (in_order_k - next_order) mod 256, computed in 8 bits with wrap.
  - Accept iff dist < DEPTH, the target slot is empty at the start of the cycle, and no lower-index channel targets the same slot this cycle.
  - Otherwise drop the packet and set error=1.
- Drain, per edge:
  - If the slot at next_order was occupied before the edge: load out_order/out_pkt from it, set out_valid=1, clear the slot, and increment next_order (8-bit wrap 255->0).
  - Otherwise out_valid=0; out_order/out_pkt hold their previous values.
- Latency: a packet sampled at edge E is presented after edge E+1 at the earliest. Peak throughput is one packet per cycle.
- Simultaneous events:
  - A write whose order equals the order being drained at the same edge targets an occupied slot, so it is an error.
  - A write of order next_order+DEPTH fails the window check, so it is an error.
  - Accepted writes and the drain at the same edge both take effect. occupancy = old + accepted - drained.
- Full buffer: inputs beyond the window are errors. There is no backpressure; the core must not retire beyond the window.
- Empty buffer: out_valid=0, and next_order waits indefinitely; there is no timeout.
- error is sticky until reset and does not stop draining of valid entries.
- Reset mid-operation discards all buffered packets with no output; next_order returns to 0.
- in_pkt/in_order are ignored for channels with in_valid=0.

Test Plan:
- In-order single channel (NRET=1): orders 0,1,2 on consecutive cycles -> out_valid high for 3 consecutive cycles starting one cycle after the first input, out_order 0,1,2; error=0.
- Reversed arrival (NRET=2): cycle0 orders {1,0}, cycle1 order 3, cycle2 order 2 -> output sequence 0,1,2,3 with payloads matching their tags; occupancy peaks at 2; error=0.
- Wrap-around: feed orders 250..255 then 0..5 in order -> output continuous, with out_order 255 immediately followed by 0; error=0.
- Out-of-window (DEPTH=16): with next_order=0 and slot 0 empty, send order 16 -> packet dropped, error=1 and held; occupancy unchanged; a later order 0 is still emitted.
- Duplicate: order 5 twice before next_order reaches 5 -> first copy emitted once, error=1. Two channels with order 7 in the same cycle -> only the channel-0 payload emitted.
- Reset mid-operation: buffer orders 2,3 (order 0 missing), assert resetn=0 for one cycle, then send 0 -> out_valid=0 throughout reset; then only order 0 emitted; occupancy=0 after the drain.

Source files
------------

// File: rtl/rvfi_reorder_buffer.sv
// rvfi_reorder_buffer
//
// Collects RVFI retirement packets that may arrive out of order on up to NRET
// channels per cycle and re-emits them one per cycle, strictly in order of
// their 8-bit order tag (mod 256). Packets are stored in a slot indexed by
// the low bits of their order tag, so a slot can only ever hold the one order
// inside the current window that maps to it.
//
// Ports
//   clk        rising-edge clock
//   resetn     synchronous active-low reset
//   in_valid   per-channel retirement valid            [NRET]
//   in_order   per-channel order tag, ch k at [k*8+:8]  [NRET*8]
//   in_pkt     per-channel payload, ch k at [k*PKTW+:PKTW]
//   out_valid  an in-order packet is presented this cycle
//   out_order  order tag of the presented packet
//   out_pkt    payload of the presented packet
//   error      sticky flag: duplicate, out-of-window or slot collision
//   occupancy  number of occupied slots
module rvfi_reorder_buffer #(
    parameter int NRET  = 1,
    parameter int DEPTH = 16,
    parameter int PKTW  = 312
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NRET-1:0]            in_valid,
    input  logic [NRET*8-1:0]          in_order,
    input  logic [NRET*PKTW-1:0]       in_pkt,
    output logic                       out_valid,
    output logic [7:0]                 out_order,
    output logic [PKTW-1:0]            out_pkt,
    output logic                       error,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int IDXW = $clog2(DEPTH);
    localparam int CNTW = IDXW + 1;

    logic [DEPTH-1:0]  slotOcc_q,   slotOcc_d;
    logic [7:0]        slotOrder_q [DEPTH];
    logic [7:0]        slotOrder_d [DEPTH];
    logic [PKTW-1:0]   slotPkt_q   [DEPTH];
    logic [PKTW-1:0]   slotPkt_d   [DEPTH];
    logic [7:0]        nextOrder_q, nextOrder_d;
    logic              outValid_q,  outValid_d;
    logic [7:0]        outOrder_q,  outOrder_d;
    logic [PKTW-1:0]   outPkt_q,    outPkt_d;
    logic              error_q,     error_d;
    logic [CNTW-1:0]   occupancy_q, occupancy_d;

    logic [NRET-1:0]   accept;
    logic              anyReject;
    logic [IDXW-1:0]   chSlot [NRET];
    logic [7:0]        chDist [NRET];
    logic [IDXW-1:0]   drainSlot;
    logic              drain;
    logic [CNTW-1:0]   acceptCount;

    // The slot for next_order can only hold next_order itself, because every
    // accepted order lies within DEPTH of next_order.
    assign drainSlot = nextOrder_q[IDXW-1:0];
    assign drain     = slotOcc_q[drainSlot];

    // Per-channel acceptance. The window distance wraps in 8 bits so the
    // window slides cleanly across 255 -> 0. Collisions are decided on slot
    // index against any lower-numbered valid channel, whether or not that
    // channel itself was accepted.
    always_comb begin
        accept    = '0;
        anyReject = 1'b0;
        for (int k = 0; k < NRET; k++) begin
            logic collide;
            chSlot[k] = in_order[k*8 +: IDXW];
            chDist[k] = in_order[k*8 +: 8] - nextOrder_q;
            collide   = 1'b0;
            for (int j = 0; j < k; j++) begin
                if (in_valid[j] && (in_order[j*8 +: IDXW] == chSlot[k])) begin
                    collide = 1'b1;
                end
            end
            if (in_valid[k]) begin
                if (({1'b0, chDist[k]} < 9'(DEPTH)) && !slotOcc_q[chSlot[k]] && !collide) begin
                    accept[k] = 1'b1;
                end else begin
                    anyReject = 1'b1;
                end
            end
        end
    end

    // Next-state for storage, drain and status. A drain and accepted writes
    // never touch the same slot: the drained slot is occupied, so any write
    // aimed at it was already rejected above.
    always_comb begin
        slotOcc_d   = slotOcc_q;
        slotOrder_d = slotOrder_q;
        slotPkt_d   = slotPkt_q;
        nextOrder_d = nextOrder_q;
        outValid_d  = 1'b0;
        outOrder_d  = outOrder_q;
        outPkt_d    = outPkt_q;
        acceptCount = '0;
        if (drain) begin
            slotOcc_d[drainSlot] = 1'b0;
            outValid_d           = 1'b1;
            outOrder_d           = slotOrder_q[drainSlot];
            outPkt_d             = slotPkt_q[drainSlot];
            nextOrder_d          = nextOrder_q + 8'd1;
        end
        for (int k = 0; k < NRET; k++) begin
            if (accept[k]) begin
                slotOcc_d[chSlot[k]]   = 1'b1;
                slotOrder_d[chSlot[k]] = in_order[k*8 +: 8];
                slotPkt_d[chSlot[k]]   = in_pkt[k*PKTW +: PKTW];
                acceptCount            = acceptCount + CNTW'(1);
            end
        end
        error_d     = error_q | anyReject;
        occupancy_d = occupancy_q + acceptCount - CNTW'(drain);
    end

    // Control and output registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            slotOcc_q   <= '0;
            nextOrder_q <= '0;
            outValid_q  <= 1'b0;
            outOrder_q  <= '0;
            outPkt_q    <= '0;
            error_q     <= 1'b0;
            occupancy_q <= '0;
        end else begin
            slotOcc_q   <= slotOcc_d;
            nextOrder_q <= nextOrder_d;
            outValid_q  <= outValid_d;
            outOrder_q  <= outOrder_d;
            outPkt_q    <= outPkt_d;
            error_q     <= error_d;
            occupancy_q <= occupancy_d;
        end
    end

    // Slot contents need no reset; they are only read when the occupied bit
    // is set, and that bit is cleared by reset.
    always_ff @(posedge clk) begin
        slotOrder_q <= slotOrder_d;
        slotPkt_q   <= slotPkt_d;
    end

    assign out_valid = outValid_q;
    assign out_order = outOrder_q;
    assign out_pkt   = outPkt_q;
    assign error     = error_q;
    assign occupancy = occupancy_q;

endmodule

// File: tb/tb_rvfi_reorder_buffer.sv
// Testbench for rvfi_reorder_buffer with two input channels and a 16-slot
// window. Expected outputs are pushed into a queue in emission order; a
// separate monitor pops and compares whenever out_valid is seen.
module tb_rvfi_reorder_buffer;

    localparam int NRET  = 2;
    localparam int DEPTH = 16;
    localparam int PKTW  = 32;

    typedef struct packed {
        logic [7:0]      order;
        logic [PKTW-1:0] pkt;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   resetn;
    logic [NRET-1:0]        in_valid;
    logic [NRET*8-1:0]      in_order;
    logic [NRET*PKTW-1:0]   in_pkt;
    logic                   out_valid;
    logic [7:0]             out_order;
    logic [PKTW-1:0]        out_pkt;
    logic                   error;
    logic [$clog2(DEPTH):0] occupancy;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;

    rvfi_reorder_buffer #(.NRET(NRET), .DEPTH(DEPTH), .PKTW(PKTW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_order  (in_order),
        .in_pkt    (in_pkt),
        .out_valid (out_valid),
        .out_order (out_order),
        .out_pkt   (out_pkt),
        .error     (error),
        .occupancy (occupancy)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    function automatic logic [PKTW-1:0] pktOf(input logic [7:0] o);
        return 32'hC0DE_0000 | {24'h0, o};
    endfunction

    function automatic logic [PKTW-1:0] pktAlt(input logic [7:0] o);
        return 32'hBAD0_0000 | {24'h0, o};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [7:0] o0, input logic [PKTW-1:0] p0,
                                 input logic v1, input logic [7:0] o1, input logic [PKTW-1:0] p1);
        in_valid = {v1, v0};
        in_order = {o1, o0};
        in_pkt   = {p1, p0};
    endtask

    task automatic idle();
        applyStimulus(1'b0, 8'd0, '0, 1'b0, 8'd0, '0);
    endtask

    task automatic sendOne(input logic [7:0] o, input logic [PKTW-1:0] p);
        applyStimulus(1'b1, o, p, 1'b0, 8'd0, '0);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pushExpected(input logic [7:0] o, input logic [PKTW-1:0] p);
        exp_t e;
        e.order = o;
        e.pkt   = p;
        expQ.push_back(e);
    endtask

    task automatic doReset();
        resetn = 1'b0;
        idle();
        step();
        step();
        resetn = 1'b1;
    endtask

    // Monitor: every presented packet must be the next one the scoreboard
    // expects; a packet with nothing expected is itself a failure.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_output: got order %0h expected none", out_order);
            end else begin
                e = expQ.pop_front();
                checkOutput("out_order", 64'(out_order), 64'(e.order));
                checkOutput("out_pkt", 64'(out_pkt), 64'(e.pkt));
            end
        end
    end

    // Directed stimulus with per-cycle status checks.
    initial begin
        logic [7:0] o;
        resetn = 1'b0;
        idle();
        step();
        step();
        checkOutput("rst out_valid", 64'(out_valid), 0);
        checkOutput("rst out_order", 64'(out_order), 0);
        checkOutput("rst out_pkt", 64'(out_pkt), 0);
        checkOutput("rst error", 64'(error), 0);
        checkOutput("rst occupancy", 64'(occupancy), 0);
        resetn = 1'b1;

        // In-order single channel: 0,1,2
        for (int i = 0; i < 3; i++) pushExpected(8'(i), pktOf(8'(i)));
        sendOne(8'd0, pktOf(8'd0)); step();
        checkOutput("t1 valid c0", 64'(out_valid), 0);
        checkOutput("t1 occ c0", 64'(occupancy), 1);
        sendOne(8'd1, pktOf(8'd1)); step();
        checkOutput("t1 valid c1", 64'(out_valid), 1);
        sendOne(8'd2, pktOf(8'd2)); step();
        checkOutput("t1 valid c2", 64'(out_valid), 1);
        checkOutput("t1 occ c2", 64'(occupancy), 1);
        idle(); step();
        checkOutput("t1 valid c3", 64'(out_valid), 1);
        checkOutput("t1 occ c3", 64'(occupancy), 0);
        step();
        checkOutput("t1 valid c4", 64'(out_valid), 0);
        checkOutput("t1 error", 64'(error), 0);

        // Reversed arrival on two channels, next_order is 3
        for (int i = 3; i < 7; i++) pushExpected(8'(i), pktOf(8'(i)));
        applyStimulus(1'b1, 8'd4, pktOf(8'd4), 1'b1, 8'd3, pktOf(8'd3)); step();
        checkOutput("t2 occ c0", 64'(occupancy), 2);
        checkOutput("t2 valid c0", 64'(out_valid), 0);
        sendOne(8'd6, pktOf(8'd6)); step();
        checkOutput("t2 occ c1", 64'(occupancy), 2);
        checkOutput("t2 valid c1", 64'(out_valid), 1);
        sendOne(8'd5, pktOf(8'd5)); step();
        checkOutput("t2 occ c2", 64'(occupancy), 2);
        idle(); step();
        checkOutput("t2 occ c3", 64'(occupancy), 1);
        step();
        checkOutput("t2 occ c4", 64'(occupancy), 0);
        checkOutput("t2 valid c4", 64'(out_valid), 1);
        step();
        checkOutput("t2 valid c5", 64'(out_valid), 0);
        checkOutput("t2 error", 64'(error), 0);

        // Wrap-around: stream 7..255 then 0..5 back to back
        for (int i = 7; i <= 261; i++) pushExpected(8'(i), pktOf(8'(i)));
        for (int i = 7; i <= 261; i++) begin
            o = 8'(i);
            sendOne(o, pktOf(o)); step();
            checkOutput("t3 stream valid", 64'(out_valid), (i > 7) ? 1 : 0);
        end
        idle(); step();
        checkOutput("t3 last valid", 64'(out_valid), 1);
        checkOutput("t3 last order", 64'(out_order), 5);
        step();
        checkOutput("t3 end valid", 64'(out_valid), 0);
        checkOutput("t3 error", 64'(error), 0);
        checkOutput("t3 occ", 64'(occupancy), 0);

        // Window edge: order 15 accepted, order 16 rejected
        doReset();
        sendOne(8'd15, pktOf(8'd15)); step();
        checkOutput("t4 edge error", 64'(error), 0);
        checkOutput("t4 edge occ", 64'(occupancy), 1);
        sendOne(8'd16, pktAlt(8'd16)); step();
        checkOutput("t4 oow error", 64'(error), 1);
        checkOutput("t4 oow occ", 64'(occupancy), 1);
        idle(); step();
        checkOutput("t4 held error", 64'(error), 1);
        checkOutput("t4 held valid", 64'(out_valid), 0);
        for (int i = 0; i < 16; i++) pushExpected(8'(i), pktOf(8'(i)));
        for (int i = 0; i < 15; i++) begin
            sendOne(8'(i), pktOf(8'(i))); step();
        end
        idle(); step(); step(); step();
        checkOutput("t4 drained occ", 64'(occupancy), 0);
        checkOutput("t4 sticky error", 64'(error), 1);

        // Duplicate order 5 across cycles
        doReset();
        for (int i = 0; i < 6; i++) pushExpected(8'(i), pktOf(8'(i)));
        sendOne(8'd5, pktOf(8'd5)); step();
        checkOutput("t5 first error", 64'(error), 0);
        sendOne(8'd5, pktAlt(8'd5)); step();
        checkOutput("t5 dup error", 64'(error), 1);
        checkOutput("t5 dup occ", 64'(occupancy), 1);
        for (int i = 0; i < 5; i++) begin
            sendOne(8'(i), pktOf(8'(i))); step();
        end
        idle(); step(); step(); step();
        checkOutput("t5 drained occ", 64'(occupancy), 0);

        // Same-cycle collision on order 7, channel 0 wins
        doReset();
        for (int i = 0; i < 8; i++) pushExpected(8'(i), pktOf(8'(i)));
        applyStimulus(1'b1, 8'd7, pktOf(8'd7), 1'b1, 8'd7, pktAlt(8'd7)); step();
        checkOutput("t5b coll error", 64'(error), 1);
        checkOutput("t5b coll occ", 64'(occupancy), 1);
        for (int i = 0; i < 7; i++) begin
            sendOne(8'(i), pktOf(8'(i))); step();
        end
        idle(); step(); step(); step();
        checkOutput("t5b drained occ", 64'(occupancy), 0);

        // Reset mid-operation discards buffered 2,3
        doReset();
        sendOne(8'd2, pktOf(8'd2)); step();
        sendOne(8'd3, pktOf(8'd3)); step();
        checkOutput("t6 pre occ", 64'(occupancy), 2);
        checkOutput("t6 pre valid", 64'(out_valid), 0);
        idle();
        resetn = 1'b0;
        step();
        checkOutput("t6 rst valid", 64'(out_valid), 0);
        checkOutput("t6 rst occ", 64'(occupancy), 0);
        resetn = 1'b1;
        pushExpected(8'd0, pktOf(8'd0));
        sendOne(8'd0, pktOf(8'd0)); step();
        checkOutput("t6 c0 valid", 64'(out_valid), 0);
        idle(); step();
        checkOutput("t6 c1 valid", 64'(out_valid), 1);
        step(); step(); step();
        checkOutput("t6 end valid", 64'(out_valid), 0);
        checkOutput("t6 end occ", 64'(occupancy), 0);
        checkOutput("t6 error", 64'(error), 0);

        checkOutput("scoreboard remaining", 64'(expQ.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
